dma_ctrl: RTL and testbench

Word-granular DMA engine sitting directly downstream of `simt_group`'s DMA command outputs. It moves `dmaWidth` 32-bit words between external DRAM and the banked scratchpad (`sram_fp`), in either direction, through one SRAM port. It stalls the SIMT group with `dmaBusy` until the transfer completes. One DRAM transaction is outstanding at a time; throughput is secondary to simplicity.

---
 rtl/dma_ctrl_if.sv | 35 +++
 rtl/dma_ctrl.sv | 131 +++++++++++++
 tb/tb_dma_ctrl.sv | 261 ++++++++++++++++++++++++++
 3 files changed

// File: rtl/dma_ctrl_if.sv
// dma_ctrl_if: command, DRAM and SRAM signals around the DMA engine.
// master is the engine's view; slave is the view of whatever surrounds it.
interface dma_ctrl_if #(
    parameter int DRAM_AW = 32,
    parameter int SRAM_AW = 14
);
    logic [1:0]         dmaCmd;
    logic [31:0]        dmaSrcAddress;
    logic [31:0]        dmaDstAddress;
    logic [9:0]         dmaWidth;
    logic               dmaBusy;
    logic               dmaDone;
    logic               dramReq;
    logic               dramWe;
    logic [DRAM_AW-1:0] dramAddr;
    logic [31:0]        dramWriteData;
    logic               dramReady;
    logic [31:0]        dramReadData;
    logic [SRAM_AW-1:0] sramAddress;
    logic               sramWriteEnable;
    logic [31:0]        sramWriteData;
    logic [31:0]        sramReadData;

    modport master (
        input  dmaCmd, dmaSrcAddress, dmaDstAddress, dmaWidth, dramReady, dramReadData, sramReadData,
        output dmaBusy, dmaDone, dramReq, dramWe, dramAddr, dramWriteData,
               sramAddress, sramWriteEnable, sramWriteData
    );

    modport slave (
        output dmaCmd, dmaSrcAddress, dmaDstAddress, dmaWidth, dramReady, dramReadData, sramReadData,
        input  dmaBusy, dmaDone, dramReq, dramWe, dramAddr, dramWriteData,
               sramAddress, sramWriteEnable, sramWriteData
    );
endinterface

// File: rtl/dma_ctrl.sv
// dma_ctrl: word-granular DMA between DRAM and the scratchpad, one DRAM transaction
// in flight; memory-side outputs are registered alongside the state.
module dma_ctrl #(
    parameter int DRAM_AW = 32,
    parameter int SRAM_AW = 14
) (
    input  logic       clk,
    input  logic       reset,
    dma_ctrl_if.master bus
);
    typedef enum logic [2:0] {IDLE, D2S_REQ, D2S_WR, S2D_RD, S2D_WAIT, S2D_REQ, DONE} state_t;

    state_t             r_state;
    logic [31:0]        r_src;
    logic [31:0]        r_dst;
    logic [9:0]         r_remain;
    logic               r_done;
    logic               r_dram_req;
    logic               r_dram_we;
    logic [DRAM_AW-1:0] r_dram_addr;
    logic [31:0]        r_dram_wdata;
    logic [SRAM_AW-1:0] r_sram_addr;
    logic               r_sram_we;
    logic [31:0]        r_sram_wdata;
    logic               w_go;
    logic               w_last;
    logic [31:0]        w_src_nx;
    logic [31:0]        w_dst_nx;

    assign w_go     = ^bus.dmaCmd;
    assign w_last   = r_remain == 10'd1;
    assign w_src_nx = r_src + 32'd4;
    assign w_dst_nx = r_dst + 32'd4;

    // Combinational so the issuing instruction stalls in the cycle it presents the command.
    assign bus.dmaBusy         = reset && (r_state == IDLE ? w_go : r_state != DONE);
    assign bus.dmaDone         = r_done;
    assign bus.dramReq         = r_dram_req;
    assign bus.dramWe          = r_dram_we;
    assign bus.dramAddr        = r_dram_addr;
    assign bus.dramWriteData   = r_dram_wdata;
    assign bus.sramAddress     = r_sram_addr;
    assign bus.sramWriteEnable = r_sram_we;
    assign bus.sramWriteData   = r_sram_wdata;

    // The write-data registers double as the single word buffer between the two memories.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_state      <= IDLE;
            r_src        <= '0;
            r_dst        <= '0;
            r_remain     <= '0;
            r_done       <= 1'b0;
            r_dram_req   <= 1'b0;
            r_dram_we    <= 1'b0;
            r_dram_addr  <= '0;
            r_dram_wdata <= '0;
            r_sram_addr  <= '0;
            r_sram_we    <= 1'b0;
            r_sram_wdata <= '0;
        end else begin
            case (r_state)
                IDLE: if (w_go) begin
                    r_src    <= bus.dmaSrcAddress;
                    r_dst    <= bus.dmaDstAddress;
                    r_remain <= bus.dmaWidth;
                    if (bus.dmaWidth == 10'd0) begin
                        r_state <= DONE;
                        r_done  <= 1'b1;
                    end else if (bus.dmaCmd == 2'b01) begin
                        r_state     <= D2S_REQ;
                        r_dram_req  <= 1'b1;
                        r_dram_we   <= 1'b0;
                        r_dram_addr <= bus.dmaSrcAddress[DRAM_AW-1:0];
                    end else begin
                        r_state     <= S2D_RD;
                        r_sram_addr <= bus.dmaSrcAddress[SRAM_AW+1:2];
                    end
                end
                D2S_REQ: if (bus.dramReady) begin
                    r_state      <= D2S_WR;
                    r_dram_req   <= 1'b0;
                    r_sram_we    <= 1'b1;
                    r_sram_addr  <= r_dst[SRAM_AW+1:2];
                    r_sram_wdata <= bus.dramReadData;
                end
                D2S_WR: begin
                    r_sram_we <= 1'b0;
                    r_src     <= w_src_nx;
                    r_dst     <= w_dst_nx;
                    r_remain  <= r_remain - 10'd1;
                    if (w_last) begin
                        r_state <= DONE;
                        r_done  <= 1'b1;
                    end else begin
                        r_state     <= D2S_REQ;
                        r_dram_req  <= 1'b1;
                        r_dram_addr <= w_src_nx[DRAM_AW-1:0];
                    end
                end
                S2D_RD: r_state <= S2D_WAIT;
                S2D_WAIT: begin
                    r_state      <= S2D_REQ;
                    r_dram_req   <= 1'b1;
                    r_dram_we    <= 1'b1;
                    r_dram_addr  <= r_dst[DRAM_AW-1:0];
                    r_dram_wdata <= bus.sramReadData;
                end
                S2D_REQ: if (bus.dramReady) begin
                    r_dram_req <= 1'b0;
                    r_dram_we  <= 1'b0;
                    r_src      <= w_src_nx;
                    r_dst      <= w_dst_nx;
                    r_remain   <= r_remain - 10'd1;
                    if (w_last) begin
                        r_state <= DONE;
                        r_done  <= 1'b1;
                    end else begin
                        r_state     <= S2D_RD;
                        r_sram_addr <= w_src_nx[SRAM_AW+1:2];
                    end
                end
                DONE: begin
                    r_state <= IDLE;
                    r_done  <= 1'b0;
                end
                default: r_state <= IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_dma_ctrl.sv
// tb_dma_ctrl: DRAM/SRAM behavioural memories plus per-word expectation queues
// derived from the transfer rules; every negedge compares the DUT against them.
module tb_dma_ctrl;
    localparam int SN = 1 << 14;

    typedef struct {
        logic [31:0] a;
        logic        we;
        logic [31:0] d;
    } op_t;

    logic clk = 1'b0;
    logic reset = 1'b0;
    int total = 0;
    int bad = 0;
    int dones = 0;
    int acc = 0;
    int delay = 0;
    bit tie = 1'b0;
    int wcnt = 0;
    logic [13:0] rd_addr = '0;
    logic p_req = 1'b0;
    logic p_rdy = 1'b0;
    logic p_we = 1'b0;
    logic [31:0] p_addr = '0;
    logic [31:0] p_data = '0;
    op_t exp_dram[$];
    op_t exp_sram[$];
    logic [31:0] dram[logic [31:0]];
    logic [31:0] sram[SN];

    dma_ctrl_if bus ();
    dma_ctrl dut (.clk(clk), .reset(reset), .bus(bus));

    always #5 clk = ~clk;

    function automatic logic [31:0] dram_rd(input logic [31:0] a);
        return dram.exists(a) ? dram[a] : (a * 32'h9E37_79B1) ^ 32'h0000_5A5A;
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h want %h at %0t", name, act, exp, $time);
        end
    endtask

    always @(negedge clk) begin
        op_t op;
        if (!reset) begin
            wcnt = 0;
            p_req = 1'b0;
            p_rdy = 1'b0;
            bus.dramReady = 1'b0;
        end else begin
            if (p_req && !p_rdy) begin
                check("req_held", bus.dramReq, 1);
                check("addr_held", bus.dramAddr, p_addr);
                check("we_held", bus.dramWe, p_we);
                if (p_we) check("wdata_held", bus.dramWriteData, p_data);
            end
            if (bus.dramReq) begin
                if (tie || wcnt == delay) begin
                    bus.dramReady = 1'b1;
                    wcnt = 0;
                end else begin
                    bus.dramReady = 1'b0;
                    wcnt++;
                end
            end else begin
                bus.dramReady = tie;
                wcnt = 0;
            end
            bus.dramReadData = dram_rd(bus.dramAddr);
            if (bus.dramReq && bus.dramReady) begin
                if (exp_dram.size() == 0) check("dram_extra", bus.dramReq, 0);
                else begin
                    op = exp_dram.pop_front();
                    check("dram_addr", bus.dramAddr, op.a);
                    check("dram_we", bus.dramWe, op.we);
                    if (op.we) begin
                        check("dram_wdata", bus.dramWriteData, op.d);
                        dram[bus.dramAddr] = bus.dramWriteData;
                    end
                end
            end
            if (bus.sramWriteEnable) begin
                if (exp_sram.size() == 0) check("sram_extra", bus.sramWriteEnable, 0);
                else begin
                    op = exp_sram.pop_front();
                    check("sram_addr", bus.sramAddress, op.a);
                    check("sram_wdata", bus.sramWriteData, op.d);
                    sram[bus.sramAddress] = bus.sramWriteData;
                end
            end
            if (bus.dmaDone) dones++;
            p_req = bus.dramReq;
            p_rdy = bus.dramReady;
            p_we = bus.dramWe;
            p_addr = bus.dramAddr;
            p_data = bus.dramWriteData;
        end
        bus.sramReadData = sram[rd_addr];
        rd_addr = bus.sramAddress;
    end

    task automatic push_exp(input logic [1:0] cmd, input logic [31:0] src, input logic [31:0] dst,
                            input logic [9:0] w);
        logic [31:0] s;
        logic [31:0] ds;
        for (int k = 0; k < int'(w); k++) begin
            s = src + 32'(4 * k);
            ds = dst + 32'(4 * k);
            if (cmd == 2'b01) begin
                exp_dram.push_back('{s, 1'b0, 32'd0});
                exp_sram.push_back('{(ds >> 2) % SN, 1'b0, dram_rd(s)});
            end else begin
                exp_dram.push_back('{ds, 1'b1, sram[(s >> 2) % SN]});
            end
        end
    endtask

    task automatic xfer(input logic [1:0] cmd, input logic [31:0] src, input logic [31:0] dst,
                        input logic [9:0] w, input int d, input bit t, output int nb);
        bit go;
        int lat;
        int n;
        go = cmd == 2'b01 || cmd == 2'b10;
        lat = !go ? 0 : w == 0 ? 1 : int'(w) * ((cmd == 2'b01 ? 2 : 3) + (t ? 0 : d)) + 1;
        nb = 0;
        delay = d;
        tie = t;
        if (go) push_exp(cmd, src, dst, w);
        @(negedge clk);
        reset = 1'b1;
        bus.dmaCmd = cmd;
        bus.dmaSrcAddress = src;
        bus.dmaDstAddress = dst;
        bus.dmaWidth = w;
        #1 check("busy_issue", bus.dmaBusy, go);
        if (!go) begin
            repeat (3) begin
                @(negedge clk);
                #1;
                check("idle_busy", bus.dmaBusy, 0);
                check("idle_done", bus.dmaDone, 0);
                check("idle_req", bus.dramReq, 0);
            end
            bus.dmaCmd = 2'b00;
            return;
        end
        acc++;
        n = 0;
        while (!bus.dmaDone && n < lat + 20) begin
            @(negedge clk);
            #1;
            n++;
            if (n == 1) check("first_req", bus.dramReq, cmd == 2'b01 && w != 0);
            if (!bus.dmaDone) begin
                nb++;
                check("busy_run", bus.dmaBusy, 1);
            end
        end
        check("done_latency", n, lat);
        check("busy_in_done", bus.dmaBusy, 0);
        bus.dmaCmd = 2'b00;
        @(negedge clk);
        #1;
        check("done_pulse", bus.dmaDone, 0);
        check("dram_left", exp_dram.size(), 0);
        check("sram_left", exp_sram.size(), 0);
    endtask

    initial begin
        int nb;
        int n;
        logic [1:0] c;
        logic [31:0] s;
        logic [31:0] dd;
        logic [31:0] orig[5];
        for (int i = 0; i < SN; i++) sram[i] = i * 32'h0100_0193 + 32'd1;
        for (int k = 0; k < 4; k++) dram[32'h1000 + 32'(4 * k)] = 32'hA0 + 32'(k);
        sram[4] = 32'd7;
        sram[5] = 32'd8;
        sram[6] = 32'd9;
        bus.dmaCmd = 2'b01;
        bus.dmaSrcAddress = 32'h1000;
        bus.dmaDstAddress = 32'h0;
        bus.dmaWidth = 10'd4;
        repeat (3) @(negedge clk);
        #1;
        check("rst_busy", bus.dmaBusy, 0);
        check("rst_done", bus.dmaDone, 0);
        check("rst_req", bus.dramReq, 0);
        check("rst_we", bus.dramWe, 0);
        check("rst_addr", bus.dramAddr, 0);
        check("rst_wdata", bus.dramWriteData, 0);
        check("rst_saddr", bus.sramAddress, 0);
        check("rst_swe", bus.sramWriteEnable, 0);
        check("rst_swdata", bus.sramWriteData, 0);

        xfer(2'b01, 32'h1000, 32'h0, 10'd4, 0, 1'b1, nb);
        check("d2s_busy_cycles", nb, 8);
        for (int k = 0; k < 4; k++) check("d2s_word", sram[k], 32'hA0 + 32'(k));

        xfer(2'b10, 32'h10, 32'h2000, 10'd3, 2, 1'b0, nb);
        for (int k = 0; k < 3; k++) check("s2d_word", dram[32'h2000 + 32'(4 * k)], 32'd7 + 32'(k));

        xfer(2'b01, 32'h40, 32'h80, 10'd0, 0, 1'b0, nb);
        check("w0_busy_cycles", nb, 0);
        xfer(2'b11, 32'h40, 32'h80, 10'd2, 0, 1'b0, nb);
        xfer(2'b01, 32'h5000, 32'h200, 10'd1, 0, 1'b0, nb);
        check("single_word", sram[128], dram_rd(32'h5000));

        // width-5 d2s, reset lands in the DRAM request of word 2
        for (int k = 0; k < 5; k++) orig[k] = sram[64 + k];
        tie = 1'b1;
        push_exp(2'b01, 32'h3000, 32'h100, 10'd5);
        @(negedge clk);
        bus.dmaCmd = 2'b01;
        bus.dmaSrcAddress = 32'h3000;
        bus.dmaDstAddress = 32'h100;
        bus.dmaWidth = 10'd5;
        n = 0;
        while (exp_sram.size() > 3 && n < 50) begin
            @(negedge clk);
            #1;
            n++;
        end
        check("rst_mid_reached", exp_sram.size(), 3);
        @(negedge clk);
        #1 reset = 1'b0;
        bus.dmaCmd = 2'b00;
        #1;
        check("rst_mid_req", bus.dramReq, 0);
        check("rst_mid_busy", bus.dmaBusy, 0);
        exp_dram.delete();
        exp_sram.delete();
        repeat (2) @(negedge clk);
        for (int k = 0; k < 2; k++) check("rst_kept", sram[64 + k], dram_rd(32'h3000 + 32'(4 * k)));
        for (int k = 2; k < 5; k++) check("rst_untouched", sram[64 + k], orig[k]);
        xfer(2'b01, 32'h3000, 32'h100, 10'd5, 1, 1'b0, nb);

        xfer(2'b01, 32'hFFFF_FFF8, 32'h0000_FFF8, 10'd4, 1, 1'b0, nb);
        xfer(2'b10, 32'h0001_FFF8, 32'hFFFF_FFFC, 10'd3, 0, 1'b1, nb);
        xfer(2'b01, 32'h8000_0000, 32'h0004_0000, 10'd1023, 0, 1'b1, nb);
        check("max_busy_cycles", nb, 2046);

        for (int i = 0; i < 30; i++) begin
            c = ($urandom_range(0, 9) < 8) ? 2'($urandom_range(1, 2)) : 2'($urandom_range(0, 1) * 3);
            s = $urandom;
            dd = $urandom;
            xfer(c, s, dd, 10'($urandom_range(0, 12)), int'($urandom_range(0, 3)), 1'($urandom_range(0, 1)), nb);
        end

        check("done_count", dones, acc);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
